// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: op codes, FSM states and alignment helper for the load/store unit.
package mem_access_unit_pkg;
  typedef enum logic [2:0] {
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_DONE} state_e;
  function automatic logic is_misaligned(op_e op, logic [1:0] lo);
    return ((op == OP_LH || op == OP_LHU || op == OP_SH) && lo[0]) ||
           ((op == OP_LW || op == OP_SW) && lo != 2'b00);
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian lane extract/extend for loads and lane merge for sub-word stores.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  op_e         op,
  input  logic [1:0]  lo,
  input  logic [31:0] rd_word,
  input  logic [31:0] merge_word,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rd_word[8*lo +: 8];
    h = lo[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = op == OP_LB  ? {{24{b[7]}}, b} :
                op == OP_LBU ? {24'h0, b} :
                op == OP_LH  ? {{16{h[15]}}, h} :
                op == OP_LHU ? {16'h0, h} : rd_word;
    store_word = merge_word;
    if (op == OP_SB) store_word[8*lo +: 8] = wdata[7:0];
    else store_word[16*lo[1] +: 16] = wdata;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressed load/store initiator onto a word-indexed memory, RMW for SB/SH.
// Define MEM_ALIGN_CHECK_EN to fault misaligned halfword/word accesses instead of ignoring low bits.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_read_data
);
  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, merge_q, merge_d, rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic              misalign, is_sub, in_access, in_write;
  logic [DATA_W-1:0] load_data, store_word;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = is_misaligned(op_e'(req_op), req_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign is_sub    = op_q == OP_SB || op_q == OP_SH;
  assign in_access = state_q == S_ACCESS;
  assign in_write  = state_q == S_WRITE;

  mem_lane_align u_align (
    .op         (op_q),
    .lo         (addr_q[1:0]),
    .rd_word    (mem_read_data),
    .merge_word (merge_q),
    .wdata      (wdata_q[15:0]),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        state_d = misalign ? S_DONE : S_ACCESS;
        op_d    = op_e'(req_op);
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rdata_d = '0;
        fault_d = misalign;
      end
      S_ACCESS: begin
        state_d = is_sub ? S_WRITE : S_DONE;
        if (is_sub) merge_d = mem_read_data;
        else if (op_q != OP_SW) rdata_d = load_data;
      end
      S_WRITE: state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        fault_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_LB;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  assign req_ready       = state_q == S_IDLE;
  assign resp_valid      = state_q == S_DONE;
  assign resp_rdata      = rdata_q;
  assign resp_fault      = fault_q;
  assign mem_access_addr = (in_access || in_write) ? {2'b00, addr_q[ADDR_W-1:2]} : '0;
  // Strobes gated by reset so an interrupted RMW never reaches memory.
  assign mem_read_en     = !reset && in_access && op_q != OP_SW;
  assign mem_write_en    = !reset && ((in_access && op_q == OP_SW) || in_write);
  assign mem_write_data  = in_write ? store_word : (in_access && op_q == OP_SW) ? wdata_q : '0;
endmodule
